// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch decision, PC redirect/flush, operand
// stall, and saturating branch statistics.
// Ports: Clk/Rst (async active-low); Valid, BranchOp, OperandReady,
// Zero, Sign, PCPlus4, Imm in; CmpMode, Stall (comb), PCSrc, FlushIFID,
// BranchTarget (registered), BranchCount, TakenCount, WaitErr out.
module branch_resolve #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Valid,
  input  logic [2:0]       BranchOp,
  input  logic             OperandReady,
  input  logic             Zero,
  input  logic             Sign,
  input  logic [31:0]      PCPlus4,
  input  logic [31:0]      Imm,
  output logic             CmpMode,
  output logic             PCSrc,
  output logic [31:0]      BranchTarget,
  output logic             FlushIFID,
  output logic             Stall,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount,
  output logic             WaitErr
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BGEZ = 3'b011;
  localparam logic [2:0] OP_BGTZ = 3'b100;
  localparam logic [2:0] OP_BLEZ = 3'b101;
  localparam logic [2:0] OP_BLTZ = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             werr_q, werr_d;
  logic             req;
  logic             taken;
  logic             eval;
  logic [31:0]      target;

  assign req     = Valid & (BranchOp != OP_NONE);
  assign target  = PCPlus4 + (Imm << 2);
  assign CmpMode = (BranchOp == OP_BEQ) | (BranchOp == OP_BNE);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (BranchOp == OP_BEQ):  taken = Zero;
      (BranchOp == OP_BNE):  taken = ~Zero;
      (BranchOp == OP_BGEZ): taken = ~Sign;
      (BranchOp == OP_BGTZ): taken = ~Sign & ~Zero;
      (BranchOp == OP_BLEZ): taken = Sign | Zero;
      (BranchOp == OP_BLTZ): taken = Sign;
      (BranchOp == OP_J):    taken = 1'b1;
      default:               taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tgt_d   = tgt_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    werr_d  = werr_q;
    Stall   = 1'b0;
    eval    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req && !OperandReady) begin
          state_d = S_WAIT;
          Stall   = 1'b1;
          wait_d  = WW'(1);
        end else if (req) begin
          eval = 1'b1;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (!OperandReady) begin
          Stall = 1'b1;
          // Already waited the allowed maximum and still not ready.
          if (wait_q == WMAX) werr_d = 1'b1;
          else wait_d = wait_q + WW'(1);
        end else begin
          eval   = 1'b1;
          wait_d = '0;
        end
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (eval) begin
      state_d = S_IDLE;
      if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
      if (taken) begin
        state_d = S_REDIR;
        tgt_d   = target;
        if (tcnt_q != '1) tcnt_d = tcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      tgt_q   <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tgt_q   <= tgt_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      werr_q  <= werr_d;
    end
  end

  assign PCSrc        = (state_q == S_REDIR);
  assign FlushIFID    = (state_q == S_REDIR);
  assign BranchTarget = tgt_q;
  assign BranchCount  = bcnt_q;
  assign TakenCount   = tcnt_q;
  assign WaitErr      = werr_q;

endmodule
